dual_issue_hazard_unit: RTL and testbench

Issue-control block for the 2-way superscalar pipeline, sitting between Decode and Execute. The forwarding logic resolves dependences by consuming producer results. This block works from the producer side: it decides when a decoded pair may not enter Execute together. It splits dependent or resource-conflicting pairs over two cycles, inserts load-use bubbles, and drives the stall, issue and oldest-way signals that the forwarding logic and pipeline registers use.

---
 rtl/dual_issue_hazard_unit.sv | 153 +++++++++++++++
 tb/tb_dual_issue_hazard_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_hazard_unit.sv
//------------------------------------------------------------------------------
// dual_issue_hazard_unit : issue control for a 2-way pipeline (split/bubble/stall)
// Optional statistics counters: define HAZARD_STATS_EN.   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dual_issue_hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Way_0_valid_D,
  input  logic             Way_1_valid_D,
  input  logic [REG_W-1:0] Way_0_rs,
  input  logic [REG_W-1:0] Way_0_rt,
  input  logic [REG_W-1:0] Way_1_rs,
  input  logic [REG_W-1:0] Way_1_rt,
  input  logic [REG_W-1:0] Way_0_rd_D,
  input  logic [REG_W-1:0] Way_1_rd_D,
  input  logic             Way_0_reg_write_D,
  input  logic             Way_1_reg_write_D,
  input  logic             Way_0_mem_D,
  input  logic             Way_1_mem_D,
  input  logic             Way_0_branch_D,
  input  logic             Way_1_branch_D,
  input  logic [REG_W-1:0] Way_0_rd_E,
  input  logic [REG_W-1:0] Way_1_rd_E,
  input  logic             Way_0_mem_read_E,
  input  logic             Way_1_mem_read_E,
  input  logic             flush,
  input  logic             freeze,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             issue_0,
  output logic             issue_1,
  output logic             Way_0_oldest_ID,
  output logic             split_active,
  output logic [CNT_W-1:0] split_count,
  output logic [CNT_W-1:0] lu_count
);

  typedef enum logic [0:0] {PAIR = 1'b0, SECOND = 1'b1} state_t;

  state_t r_state;
  state_t w_next;

  logic w_lu0, w_lu1, w_raw, w_waw, w_mem, w_br, w_split;
  logic w_stall, w_iss0, w_iss1, w_lu_bubble, w_split_start;

  // A source hits a load in EX only when it is a non-zero register.
  function automatic logic f_lu(input logic [REG_W-1:0] src,
                                input logic [REG_W-1:0] rd0,
                                input logic [REG_W-1:0] rd1,
                                input logic             ld0,
                                input logic             ld1);
    return (src != '0) && ((ld0 && (src == rd0)) || (ld1 && (src == rd1)));
  endfunction

  assign w_lu0 = Way_0_valid_D &&
                 (f_lu(Way_0_rs, Way_0_rd_E, Way_1_rd_E, Way_0_mem_read_E, Way_1_mem_read_E) ||
                  f_lu(Way_0_rt, Way_0_rd_E, Way_1_rd_E, Way_0_mem_read_E, Way_1_mem_read_E));
  assign w_lu1 = Way_1_valid_D &&
                 (f_lu(Way_1_rs, Way_0_rd_E, Way_1_rd_E, Way_0_mem_read_E, Way_1_mem_read_E) ||
                  f_lu(Way_1_rt, Way_0_rd_E, Way_1_rd_E, Way_0_mem_read_E, Way_1_mem_read_E));

  assign w_raw = Way_0_reg_write_D && (Way_0_rd_D != '0) &&
                 ((Way_0_rd_D == Way_1_rs) || (Way_0_rd_D == Way_1_rt));
  assign w_waw = Way_0_reg_write_D && Way_1_reg_write_D && (Way_0_rd_D != '0) &&
                 (Way_0_rd_D == Way_1_rd_D);
  assign w_mem = Way_0_mem_D && Way_1_mem_D;
  assign w_br  = Way_0_branch_D && Way_1_branch_D;
  assign w_split = Way_0_valid_D && Way_1_valid_D && (w_raw || w_waw || w_mem || w_br);

  always_ff @(posedge clk) begin
    if (rst) r_state <= PAIR;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_stall       = 1'b0;
    w_iss0        = 1'b0;
    w_iss1        = 1'b0;
    w_lu_bubble   = 1'b0;
    w_split_start = 1'b0;
    if (flush) begin
      w_next = PAIR;
    end else if (freeze) begin
      w_stall = 1'b1;
    end else begin
      case (r_state)
        PAIR: begin
          if (w_lu0 || (w_lu1 && !w_split)) begin
            w_stall     = 1'b1;
            w_lu_bubble = 1'b1;
          end else if (w_split) begin
            w_iss0        = 1'b1;
            w_stall       = 1'b1;
            w_split_start = 1'b1;
            w_next        = SECOND;
          end else begin
            w_iss0 = Way_0_valid_D;
            w_iss1 = Way_1_valid_D;
          end
        end
        SECOND: begin
          if (w_lu1) begin
            w_stall     = 1'b1;
            w_lu_bubble = 1'b1;
          end else begin
            w_iss1 = 1'b1;
            w_next = PAIR;
          end
        end
        default: w_next = PAIR;
      endcase
    end
  end

  // Outputs are forced low for the whole reset cycle, not just after the edge.
  assign stall_IF        = !rst && w_stall;
  assign stall_ID        = !rst && w_stall;
  assign issue_0         = !rst && w_iss0;
  assign issue_1         = !rst && w_iss1;
  assign Way_0_oldest_ID = !rst && (r_state == PAIR);
  assign split_active    = !rst && (r_state == SECOND);

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] r_split_cnt, r_lu_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_split_cnt <= '0;
      r_lu_cnt    <= '0;
    end else begin
      if (w_split_start && !(&r_split_cnt)) r_split_cnt <= r_split_cnt + 1'b1;
      if (w_lu_bubble && !(&r_lu_cnt))      r_lu_cnt    <= r_lu_cnt + 1'b1;
    end
  end

  assign split_count = rst ? '0 : r_split_cnt;
  assign lu_count    = rst ? '0 : r_lu_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_split_start ^ w_lu_bubble;
  assign split_count    = '0;
  assign lu_count       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dual_issue_hazard_unit.sv
//------------------------------------------------------------------------------
// tb_dual_issue_hazard_unit : directed self-checking bench for the issue unit
// Counter expectations follow HAZARD_STATS_EN.   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dual_issue_hazard_unit;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic Way_0_valid_D, Way_1_valid_D;
  logic [REG_W-1:0] Way_0_rs, Way_0_rt, Way_1_rs, Way_1_rt;
  logic [REG_W-1:0] Way_0_rd_D, Way_1_rd_D, Way_0_rd_E, Way_1_rd_E;
  logic Way_0_reg_write_D, Way_1_reg_write_D, Way_0_mem_D, Way_1_mem_D;
  logic Way_0_branch_D, Way_1_branch_D, Way_0_mem_read_E, Way_1_mem_read_E;
  logic flush, freeze;
  logic stall_IF, stall_ID, issue_0, issue_1, Way_0_oldest_ID, split_active;
  logic [CNT_W-1:0] split_count, lu_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dual_issue_hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Way_0_valid_D(Way_0_valid_D), .Way_1_valid_D(Way_1_valid_D),
    .Way_0_rs(Way_0_rs), .Way_0_rt(Way_0_rt), .Way_1_rs(Way_1_rs), .Way_1_rt(Way_1_rt),
    .Way_0_rd_D(Way_0_rd_D), .Way_1_rd_D(Way_1_rd_D),
    .Way_0_reg_write_D(Way_0_reg_write_D), .Way_1_reg_write_D(Way_1_reg_write_D),
    .Way_0_mem_D(Way_0_mem_D), .Way_1_mem_D(Way_1_mem_D),
    .Way_0_branch_D(Way_0_branch_D), .Way_1_branch_D(Way_1_branch_D),
    .Way_0_rd_E(Way_0_rd_E), .Way_1_rd_E(Way_1_rd_E),
    .Way_0_mem_read_E(Way_0_mem_read_E), .Way_1_mem_read_E(Way_1_mem_read_E),
    .flush(flush), .freeze(freeze),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .issue_0(issue_0), .issue_1(issue_1),
    .Way_0_oldest_ID(Way_0_oldest_ID), .split_active(split_active),
    .split_count(split_count), .lu_count(lu_count)
  );

  // Output vector: {stall_IF, stall_ID, issue_0, issue_1, oldest, split_active}
  task automatic chk_out(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {stall_IF, stall_ID, issue_0, issue_1, Way_0_oldest_ID, split_active};
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int cexp(input int n);
`ifdef HAZARD_STATS_EN
    return (n > 15) ? 15 : n;
`else
    return 0;
`endif
  endfunction

  task automatic chk_cnt(input string tag, input int exp_split, input int exp_lu);
    logic [CNT_W-1:0] es, el;
    es = CNT_W'(cexp(exp_split));
    el = CNT_W'(cexp(exp_lu));
    n_checks++;
    assert ({split_count, lu_count} === {es, el}) else begin
      n_errors++;
      $error("FAIL %s: observed split=%0d lu=%0d expected split=%0d lu=%0d",
             tag, split_count, lu_count, es, el);
    end
  endtask

  task automatic clr();
    Way_0_valid_D = 0; Way_1_valid_D = 0;
    Way_0_rs = 0; Way_0_rt = 0; Way_1_rs = 0; Way_1_rt = 0;
    Way_0_rd_D = 0; Way_1_rd_D = 0;
    Way_0_reg_write_D = 0; Way_1_reg_write_D = 0;
    Way_0_mem_D = 0; Way_1_mem_D = 0; Way_0_branch_D = 0; Way_1_branch_D = 0;
    Way_0_rd_E = 0; Way_1_rd_E = 0; Way_0_mem_read_E = 0; Way_1_mem_read_E = 0;
    flush = 0; freeze = 0;
  endtask

  // add r3,r1,r2 | sub r6,r4,r5
  task automatic indep();
    clr();
    Way_0_valid_D = 1; Way_0_rs = 1; Way_0_rt = 2; Way_0_rd_D = 3; Way_0_reg_write_D = 1;
    Way_1_valid_D = 1; Way_1_rs = 4; Way_1_rt = 5; Way_1_rd_D = 6; Way_1_reg_write_D = 1;
  endtask

  // add r3,r1,r2 | or r7,r3,r4
  task automatic raw_pair();
    indep();
    Way_1_rs = 3; Way_1_rt = 4; Way_1_rd_D = 7;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1;
    indep();
    #1;
    chk_out("reset_outputs", 6'b000000);
    chk_cnt("reset_counters", 0, 0);
    tick();
    rst = 0;

    indep(); #1; chk_out("indep_pair", 6'b001110); tick();
    indep(); #1; chk_out("indep_pair_again", 6'b001110); tick();

    raw_pair(); #1; chk_out("raw_cycle0", 6'b111010); tick();
    #1; chk_out("raw_cycle1", 6'b000101);
    chk_cnt("raw_split_count", 1, 0); tick();

    indep(); Way_0_rs = 8; Way_1_rd_E = 8; Way_1_mem_read_E = 1;
    #1; chk_out("load_use_bubble", 6'b110010); tick();
    Way_1_mem_read_E = 0; Way_1_rd_E = 0;
    #1; chk_out("load_use_release", 6'b001110);
    chk_cnt("load_use_count", 1, 1); tick();

    indep(); Way_0_rd_D = 0; Way_1_rs = 0;
    #1; chk_out("zero_reg_no_split", 6'b001110); tick();

    indep(); Way_0_mem_D = 1; Way_1_mem_D = 1;
    #1; chk_out("mem_split", 6'b111010); tick();
    flush = 1;
    #1; chk_out("flush_in_second", 6'b000001); tick();
    indep(); #1; chk_out("after_flush_pair", 6'b001110);
    chk_cnt("after_flush_counts", 2, 1); tick();

    raw_pair(); flush = 1;
    #1; chk_out("flush_beats_hazard", 6'b000010); tick();
    indep(); #1; chk_out("after_flush_hazard", 6'b001110); tick();

    indep(); Way_0_branch_D = 1; Way_1_branch_D = 1;
    #1; chk_out("br_split", 6'b111010); tick();
    freeze = 1;
    #1; chk_out("freeze_second_a", 6'b110001); tick();
    #1; chk_out("freeze_second_b", 6'b110001);
    chk_cnt("freeze_holds_counts", 3, 1); tick();
    freeze = 0;
    #1; chk_out("freeze_resume_second", 6'b000101); tick();

    indep(); Way_0_rd_D = 5; Way_1_rd_D = 5;
    #1; chk_out("waw_split", 6'b111010); tick();
    Way_0_rd_E = 9; Way_0_mem_read_E = 1; Way_1_rt = 9;
    #1; chk_out("lu1_in_second", 6'b110001); tick();
    Way_0_mem_read_E = 0;
    #1; chk_out("second_after_lu1", 6'b000101); tick();

    raw_pair(); Way_1_rt = 8; Way_0_rd_E = 8; Way_0_mem_read_E = 1;
    #1; chk_out("lu1_with_split", 6'b111010); tick();
    #1; chk_out("lu1_with_split_second", 6'b110001); tick();
    Way_0_mem_read_E = 0;
    #1; chk_out("lu1_with_split_done", 6'b000101); tick();

    indep(); Way_1_rs = 8; Way_0_rd_E = 8; Way_0_mem_read_E = 1;
    #1; chk_out("lu1_no_split_stall", 6'b110010); tick();
    raw_pair(); Way_1_valid_D = 0;
    #1; chk_out("invalid_way1_no_split", 6'b001010);
    chk_cnt("pre_reset_counts", 5, 4); tick();

    raw_pair(); #1; chk_out("split_before_reset", 6'b111010); tick();
    rst = 1;
    #1; chk_out("reset_mid_split", 6'b000000);
    chk_cnt("reset_mid_split_counts", 0, 0); tick();
    rst = 0; indep();
    #1; chk_out("pair_after_reset", 6'b001110);
    chk_cnt("counts_after_reset", 0, 0); tick();

    for (int i = 0; i < 17; i++) begin
      raw_pair(); tick(); tick();
    end
    clr();
    #1; chk_cnt("split_saturation", 17, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
